alu_mc: RTL

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 115 +++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// Multi-cycle 32-bit ALU. Logic and arithmetic ops complete in one cycle.
// Shifts move one bit per cycle, so an n-bit shift takes n+1 cycles.
module alu_mc (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  alucontrol,
  input  logic [1:0]  shtype,
  input  logic        alu2src,
  input  logic        sltunsigned,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        zero
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state, state_next;
  logic [DATA_W-1:0] acc;
  logic [4:0]        cnt;
  logic [1:0]        sht;
  logic              shift_req;
  logic [DATA_W-1:0] direct_res;
  logic [DATA_W-1:0] acc_step;

  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v,
                                                  input logic [1:0] t);
    case (t)
      2'b01:   return {1'b0, v[DATA_W-1:1]};
      2'b10:   return {v[DATA_W-1], v[DATA_W-1:1]};
      default: return {v[DATA_W-2:0], 1'b0};
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu_op(input logic [2:0] ctl,
                                               input logic uns,
                                               input logic [DATA_W-1:0] x,
                                               input logic [DATA_W-1:0] y);
    logic signed [DATA_W-1:0] sx;
    logic signed [DATA_W-1:0] sy;
    sx = x;
    sy = y;
    case (ctl)
      3'b000:  return x & y;
      3'b001:  return x | y;
      3'b010:  return x + y;
      3'b110:  return x - y;
      3'b111:  return uns ? {{(DATA_W-1){1'b0}}, x < y} : {{(DATA_W-1){1'b0}}, sx < sy};
      default: return '0;
    endcase
  endfunction

  // A zero shift amount needs no iteration: the operand is the result.
  assign shift_req  = alu2src && (b[4:0] != 5'd0);
  assign direct_res = alu2src ? a : alu_op(alucontrol, sltunsigned, a, b);
  assign acc_step   = shift_one(acc, sht);
  assign zero       = (result == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_next = shift_req ? SHIFT : DONE;
      end
      SHIFT: if (cnt == 5'd1) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      sht    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (shift_req) begin
            acc <= a;
            cnt <= b[4:0];
            sht <= shtype;
          end else begin
            result <= direct_res;
          end
        end
        // The last step's output is written straight into result.
        SHIFT: begin
          acc <= acc_step;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) result <= acc_step;
        end
        default: ;
      endcase
    end
  end

endmodule
